multiplication_apply_seq: RTL and testbench

//  Sequential element-wise signed multiply: mem[dst+k] = mem[dst+k] * mem[src+k], k = 0..length-1.

---
 rtl/multiplication_apply_seq.sv | 116 +++++++++++
 tb/tb_multiplication_apply_seq.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multiplication_apply_seq.sv
// Sequential element-wise signed multiply-in-place: mem[dst+k] *= mem[src+k], one element per 3-cycle slot.
// Optional build macro SATURATE_MUL_EN clamps each product to the DATA_W signed range instead of wrapping.
module multiplication_apply_seq #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        dst_addr,
  input  logic [ADDR_W-1:0]        src_addr,
  input  logic [LEN_W-1:0]         length,
  output logic                     busy,
  output logic                     done,
  output logic                     rd_en,
  output logic [ADDR_W-1:0]        rd_addr_a,
  output logic [ADDR_W-1:0]        rd_addr_b,
  input  logic signed [DATA_W-1:0] rd_data_a,
  input  logic signed [DATA_W-1:0] rd_data_b,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic signed [DATA_W-1:0] wr_data
);

  typedef enum logic [2:0] {IDLE, READ, MUL, WRITE, DONE} state_t;

  state_t                     state, state_nxt;
  logic [ADDR_W-1:0]          dst_q, src_q;
  logic [LEN_W-1:0]           len_q, cnt_q;
  logic [ADDR_W-1:0]          k_addr;
  logic signed [DATA_W-1:0]   prod_p0, prod_p1;
  logic                       last_elem;

`ifdef SATURATE_MUL_EN
  localparam logic signed [2*DATA_W-1:0] SAT_MAX = {{(DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [2*DATA_W-1:0] SAT_MIN = {{(DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  function automatic logic signed [DATA_W-1:0] saturate(input logic signed [2*DATA_W-1:0] p);
    if (p > SAT_MAX)      return SAT_MAX[DATA_W-1:0];
    else if (p < SAT_MIN) return SAT_MIN[DATA_W-1:0];
    else                  return p[DATA_W-1:0];
  endfunction

  logic signed [2*DATA_W-1:0] full_p0;
  assign full_p0 = rd_data_a * rd_data_b;
  assign prod_p0 = saturate(full_p0);
`else
  // Evaluated at DATA_W width: identical to the low half of the full product (wrap).
  assign prod_p0 = rd_data_a * rd_data_b;
`endif

  assign k_addr    = ADDR_W'(cnt_q);
  assign last_elem = (cnt_q == len_q - LEN_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      dst_q   <= '0;
      src_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      prod_p1 <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        dst_q <= dst_addr;
        src_q <= src_addr;
        len_q <= length;
        cnt_q <= '0;
      end
      // read data -> product register (MUL stage)
      if (state == MUL) prod_p1 <= prod_p0;
      if (state == WRITE) cnt_q <= cnt_q + LEN_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = (length == '0) ? DONE : READ;
      end
      READ: begin
        busy      = 1'b1;
        rd_en     = 1'b1;
        state_nxt = MUL;
      end
      MUL: begin
        busy      = 1'b1;
        state_nxt = WRITE;
      end
      WRITE: begin
        busy      = 1'b1;
        wr_en     = 1'b1;
        state_nxt = last_elem ? DONE : READ;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // product register -> RAM write port (WRITE stage)
  assign rd_addr_a = dst_q + k_addr;
  assign rd_addr_b = src_q + k_addr;
  assign wr_addr   = dst_q + k_addr;
  assign wr_data   = prod_p1;

endmodule

// File: tb/tb_multiplication_apply_seq.sv
// Scoreboard bench for multiplication_apply_seq: a behavioural RAM, a golden memory model and a write queue.
// Build with +define+SATURATE_MUL_EN to exercise the saturating variant.
module tb_multiplication_apply_seq;
  logic               clk = 1'b0;
  logic               rst, start;
  logic [7:0]         dst_addr, src_addr, length;
  logic               busy, done, rd_en, wr_en;
  logic [7:0]         rd_addr_a, rd_addr_b, wr_addr;
  logic signed [31:0] rd_data_a, rd_data_b, wr_data;

  multiplication_apply_seq #(.ADDR_W(8), .LEN_W(8), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .dst_addr(dst_addr), .src_addr(src_addr),
    .length(length), .busy(busy), .done(done), .rd_en(rd_en), .rd_addr_a(rd_addr_a),
    .rd_addr_b(rd_addr_b), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  logic [31:0] mem  [256];
  logic [31:0] gold [256];

  always @(posedge clk) begin
    if (rd_en) begin
      rd_data_a <= mem[rd_addr_a];
      rd_data_b <= mem[rd_addr_b];
    end
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  typedef struct { logic [7:0] a; logic [31:0] d; } wr_t;
  wr_t sb[$];
  wr_t exp_wr;

  int n_vec = 0, n_miss = 0;
  int rd_cnt = 0, wr_cnt = 0, done_cnt = 0, busy_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rd_en) rd_cnt++;
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    if (wr_en) begin
      wr_cnt++;
      if (sb.size() == 0) begin
        check("wr_unexpected", 32'(wr_addr), 32'hFFFF_FFFF);
      end else begin
        exp_wr = sb.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(exp_wr.a));
        check("wr_data", wr_data, exp_wr.d);
      end
    end
  end

  function automatic logic [31:0] model_mul(input logic [31:0] a, input logic [31:0] b);
    longint p = longint'($signed(a)) * longint'($signed(b));
`ifdef SATURATE_MUL_EN
    if (p > 64'sd2147483647)  return 32'h7FFF_FFFF;
    if (p < -64'sd2147483648) return 32'h8000_0000;
`endif
    return p[31:0];
  endfunction

  // Golden in-order model; nw < len models an operation cut short by reset.
  task automatic model_op(input logic [7:0] d, input logic [7:0] s, input int nw);
    for (int k = 0; k < nw; k++) begin
      logic [7:0] ad, as;
      ad = d + 8'(k);
      as = s + 8'(k);
      gold[ad] = model_mul(gold[ad], gold[as]);
      sb.push_back('{ad, gold[ad]});
    end
  endtask

  task automatic setw(input logic [7:0] a, input logic [31:0] v);
    mem[a]  = v;
    gold[a] = v;
  endtask

  task automatic mem_check(input string tag);
    int diff = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== gold[i]) diff++;
    check(tag, 32'(diff), 32'd0);
    check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic start_op(input logic [7:0] d, input logic [7:0] s, input logic [7:0] l);
    @(negedge clk);
    start = 1'b1; dst_addr = d; src_addr = s; length = l;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Cycle c (c>=1) is the c-th cycle after the start-sampling edge.
  task automatic wait_done(input int n);
    bit seen = 1'b0;
    bit busy_ok = 1'b1;
    for (int c = 1; c <= 3 * n + 10; c++) begin
      @(negedge clk);
      if (busy !== (c <= 3 * n)) busy_ok = 1'b0;
      if (done) begin
        check("done_cycle", 32'(c), 32'(3 * n + 1));
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
    check("busy_window", 32'(busy_ok), 32'd1);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc, rc, wc, bc;
    rst = 1'b1; start = 1'b0; dst_addr = '0; src_addr = '0; length = '0;
    for (int i = 0; i < 256; i++) setw(8'(i), 32'(i * 3 + 1));
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rd_en", 32'(rd_en), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_rd_addr_a", 32'(rd_addr_a), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    @(negedge clk) rst = 1'b0;

    // Basic
    setw(0, 3); setw(1, -4); setw(2, 7); setw(3, 0); setw(4, 54);
    setw(16, 5); setw(17, 6); setw(18, -2); setw(19, 9);
    model_op(0, 16, 4);
    start_op(0, 16, 4);
    wait_done(4);
    check("t1_m0", mem[0], 32'd15);
    check("t1_m1", mem[1], 32'(-24));
    check("t1_m2", mem[2], 32'(-14));
    check("t1_m3", mem[3], 32'd0);
    check("t1_m4", mem[4], 32'd54);
    check("t1_m18", mem[18], 32'(-2));
    mem_check("t1_mem");

    // Overflow
    setw(0, 32'h4000_0000); setw(1, 32'hC000_0000); setw(16, 4); setw(17, 4);
    model_op(0, 16, 2);
    start_op(0, 16, 2);
    wait_done(2);
`ifdef SATURATE_MUL_EN
    check("t2_m0", mem[0], 32'h7FFF_FFFF);
    check("t2_m1", mem[1], 32'h8000_0000);
`else
    check("t2_m0", mem[0], 32'h0000_0000);
    check("t2_m1", mem[1], 32'h0000_0000);
`endif
    mem_check("t2_mem");

    // Overlap: each element reads the previous element's fresh result
    setw(0, 2); setw(1, 3); setw(2, 4); setw(3, 5);
    model_op(1, 0, 3);
    start_op(1, 0, 3);
    wait_done(3);
    check("t3_m0", mem[0], 32'd2);
    check("t3_m1", mem[1], 32'd6);
    check("t3_m2", mem[2], 32'd24);
    check("t3_m3", mem[3], 32'd120);
    mem_check("t3_mem");

    // Zero length
    rc = rd_cnt; wc = wr_cnt; bc = busy_cnt;
    start_op(5, 9, 0);
    wait_done(0);
    #1;
    check("t4_rd_en", 32'(rd_cnt - rc), 32'd0);
    check("t4_wr_en", 32'(wr_cnt - wc), 32'd0);
    check("t4_busy", 32'(busy_cnt - bc), 32'd0);
    mem_check("t4_mem");

    // Start while busy is ignored
    setw(0, -3); setw(1, 11); setw(2, 100); setw(3, -1);
    setw(16, 7); setw(17, -5); setw(18, 2); setw(19, 13);
    dc = done_cnt;
    model_op(0, 16, 4);
    start_op(0, 16, 4);
    fork
      wait_done(4);
      begin
        @(posedge clk);
        #1 start = 1'b1; dst_addr = 100; src_addr = 120; length = 2;
        @(posedge clk);
        #1 start = 1'b0;
      end
    join
    @(posedge clk);
    #1;
    check("t5_done_pulses", 32'(done_cnt - dc), 32'd1);
    mem_check("t5_mem");

    // Reset mid-operation, then a clean run
    setw(0, 1); setw(1, 2); setw(2, 3); setw(3, 4);
    setw(16, 5); setw(17, 6); setw(18, 7); setw(19, 8);
    dc = done_cnt;
    model_op(0, 16, 1);
    start_op(0, 16, 4);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_rd_en", 32'(rd_en), 32'd0);
    check("t6_wr_en", 32'(wr_en), 32'd0);
    check("t6_wr_addr", 32'(wr_addr), 32'd0);
    check("t6_wr_data", wr_data, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check("t6_no_done", 32'(done_cnt - dc), 32'd0);
    check("t6_m0", mem[0], 32'd5);
    check("t6_m1", mem[1], 32'd2);
    mem_check("t6_mem");
    model_op(0, 16, 4);
    start_op(0, 16, 4);
    wait_done(4);
    mem_check("t6_rerun_mem");

    // Address wrap-around at the top of the RAM
    setw(254, 9); setw(255, -8); setw(0, 6); setw(1, 12);
    setw(100, 3); setw(101, 3); setw(102, -7); setw(103, 2);
    model_op(254, 100, 4);
    start_op(254, 100, 4);
    wait_done(4);
    check("t7_m255", mem[255], 32'(-24));
    mem_check("t7_mem");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
